control_unit: RTL and testbench

//  Hardwired Moore control sequencer directly upstream of datapath: decodes IR, steps T0..T7, drives every

---
 rtl/control_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_control_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit -- hardwired Moore control sequencer for the datapath.
//
// Steps RST -> T0..T7 (one step per Clock) and raises the datapath control
// strobes for the current step of the instruction held in IR. The opcode is
// IR[IRW-1 -: OPW]. The register fields Ra/Rb/Rc are selected in the datapath
// through Gra/Grb/Grc, so they are not decoded here.
//
// Optional feature: define CU_SINGLE_STEP_EN to add the Step input and a WAIT
// state. Each instruction boundary then parks in WAIT until Step rises.
//
// Ports
//   Clock, Reset       clock; synchronous active-high reset (state -> RST)
//   IR[IRW-1:0]        instruction register contents
//   CON                branch condition, only consulted in br T6
//   Stop               halt request, honoured at an instruction boundary
//   Step               single-step advance (CU_SINGLE_STEP_EN only)
//   PCout..OUTPORTin   one-bit datapath strobes
//   alu_op[OPW-1:0]    ALU function: opcode in ALU steps, ADD for address calc
//   Run                1 while executing T0..T7
module control_unit #(
  parameter int OPW = 5,
  parameter int IRW = 32
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [IRW-1:0] IR,
  input  logic           CON,
  input  logic           Stop,
`ifdef CU_SINGLE_STEP_EN
  input  logic           Step,
`endif
  output logic           PCout,
  output logic           PCin,
  output logic           IncPC,
  output logic           MARin,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Read,
  output logic           write,
  output logic           Yin,
  output logic           Zin,
  output logic           ZHIout,
  output logic           ZLOout,
  output logic           HIin,
  output logic           LOin,
  output logic           HIout,
  output logic           LOout,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           Cout,
  output logic           CONin,
  output logic           INPORTout,
  output logic           OUTPORTin,
  output logic [OPW-1:0] alu_op,
  output logic           Run
);

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01000;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01001;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01010;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01011;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01100;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
  localparam logic [OPW-1:0] OP_IN   = 5'b10101;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
  localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPW-1:0] OP_HALT = 5'b11010;

  // T0..T7 are consecutive so the sequencer can simply increment.
  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
`ifdef CU_SINGLE_STEP_EN
    S_WAIT = 4'd10,
`endif
    S_HALT = 4'd9
  } state_t;

  state_t         state;
  state_t         last_step;
  state_t         boundary_next;
  logic [OPW-1:0] op;
  logic           unused_ir_fields;

  assign op               = IR[IRW-1 -: OPW];
  assign unused_ir_fields = ^IR[IRW-OPW-1:0];

`ifdef CU_SINGLE_STEP_EN
  logic step_prev;
  assign boundary_next = S_WAIT;
`else
  assign boundary_next = S_T0;
`endif

  // Final step of each instruction; nop, halt and unassigned opcodes end at T2.
  always_comb begin
    last_step = S_T2;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:        last_step = S_T5;
      OP_MUL, OP_DIV, OP_BR:                   last_step = S_T6;
      OP_LD, OP_ST:                            last_step = S_T7;
      OP_JAL:                                  last_step = S_T4;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:  last_step = S_T3;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_RST;
`ifdef CU_SINGLE_STEP_EN
      step_prev <= 1'b0;
`endif
    end else begin
`ifdef CU_SINGLE_STEP_EN
      step_prev <= Step;
`endif
      case (state)
        S_RST:  state <= S_T0;
        S_HALT: state <= S_HALT;
`ifdef CU_SINGLE_STEP_EN
        S_WAIT: begin
          if (Stop)
            state <= S_HALT;
          else if (Step && !step_prev)
            state <= S_T0;
        end
`endif
        default: begin
          if (state == S_T2 && op == OP_HALT)
            state <= S_HALT;
          else if (state == last_step)
            state <= Stop ? S_HALT : boundary_next;
          else
            state <= state_t'(state + 4'd1);
        end
      endcase
    end
  end

  // Strobes are decoded from the registered step and IR rather than registered
  // themselves: IR is only loaded at the end of T2, so a registered decode
  // would see the previous instruction on entry to T3.
  always_comb begin
    PCout = 1'b0;  PCin = 1'b0;  IncPC = 1'b0;  MARin = 1'b0;
    MDRin = 1'b0;  MDRout = 1'b0;  IRin = 1'b0;  Read = 1'b0;
    write = 1'b0;  Yin = 1'b0;  Zin = 1'b0;  ZHIout = 1'b0;
    ZLOout = 1'b0;  HIin = 1'b0;  LOin = 1'b0;  HIout = 1'b0;
    LOout = 1'b0;  Gra = 1'b0;  Grb = 1'b0;  Grc = 1'b0;
    Rin = 1'b0;  Rout = 1'b0;  BAout = 1'b0;  Cout = 1'b0;
    CONin = 1'b0;  INPORTout = 1'b0;  OUTPORTin = 1'b0;
    alu_op = '0;
    Run = state inside {[S_T0:S_T7]};
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; IncPC = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI:     begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_MUL, OP_DIV:               begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_LD, OP_LDI, OP_ST:         begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          OP_BR:                        begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          OP_JR:                        begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_JAL:                       begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          OP_IN:                        begin INPORTout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:                       begin Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1; end
          OP_MFHI:                      begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO:                      begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
          OP_ADDI, OP_ANDI, OP_ORI:      begin Cout = 1'b1; Zin = 1'b1; alu_op = op; end
          OP_MUL, OP_DIV:                begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
          OP_LD, OP_LDI, OP_ST:          begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
          OP_BR:                         begin PCout = 1'b1; Yin = 1'b1; end
          OP_JAL:                        begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MUL, OP_DIV:                   begin ZLOout = 1'b1; LOin = 1'b1; end
          OP_LD, OP_ST:                     begin ZLOout = 1'b1; MARin = 1'b1; end
          OP_BR:                            begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op)
          OP_MUL, OP_DIV: begin ZHIout = 1'b1; HIin = 1'b1; end
          OP_LD:          begin Read = 1'b1; MDRin = 1'b1; end
          OP_ST:          begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          // Branch target is always computed; CON decides whether PC takes it.
          OP_BR:          begin ZLOout = 1'b1; PCin = CON; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op)
          OP_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST: write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the stimulus process applies inputs for one
// clock edge and queues the full output word expected after that edge; an
// independent monitor pops and compares on every falling edge.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IR    = '0;
  logic        CON   = 1'b0;
  logic        Stop  = 1'b0;
`ifdef CU_SINGLE_STEP_EN
  logic        Step  = 1'b0;
`else
  logic        step_unused;
`endif

  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, write;
  logic Yin, Zin, ZHIout, ZLOout, HIin, LOin, HIout, LOout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, INPORTout, OUTPORTin;
  logic [4:0] alu_op;
  logic       Run;

  control_unit #(.OPW(5), .IRW(32)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON(CON), .Stop(Stop),
`ifdef CU_SINGLE_STEP_EN
    .Step(Step),
`endif
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Read(Read), .write(write),
    .Yin(Yin), .Zin(Zin), .ZHIout(ZHIout), .ZLOout(ZLOout), .HIin(HIin),
    .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .CONin(CONin), .INPORTout(INPORTout), .OUTPORTin(OUTPORTin),
    .alu_op(alu_op), .Run(Run)
  );

  always #5 Clock = ~Clock;

  // Observed word layout: {Run, alu_op, strobes...}
  logic [32:0] act;
  assign act = {Run, alu_op, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
                Read, write, Yin, Zin, ZHIout, ZLOout, HIin, LOin, HIout, LOout,
                Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, INPORTout, OUTPORTin};

  localparam logic [32:0] OUTPORTIN = 33'h1 << 0;
  localparam logic [32:0] INPORTOUT = 33'h1 << 1;
  localparam logic [32:0] CONIN     = 33'h1 << 2;
  localparam logic [32:0] COUT      = 33'h1 << 3;
  localparam logic [32:0] BAOUT     = 33'h1 << 4;
  localparam logic [32:0] ROUT      = 33'h1 << 5;
  localparam logic [32:0] RIN       = 33'h1 << 6;
  localparam logic [32:0] GRC       = 33'h1 << 7;
  localparam logic [32:0] GRB       = 33'h1 << 8;
  localparam logic [32:0] GRA       = 33'h1 << 9;
  localparam logic [32:0] LOOUT     = 33'h1 << 10;
  localparam logic [32:0] HIOUT     = 33'h1 << 11;
  localparam logic [32:0] LOIN      = 33'h1 << 12;
  localparam logic [32:0] HIIN      = 33'h1 << 13;
  localparam logic [32:0] ZLOOUT    = 33'h1 << 14;
  localparam logic [32:0] ZHIOUT    = 33'h1 << 15;
  localparam logic [32:0] ZIN       = 33'h1 << 16;
  localparam logic [32:0] YIN       = 33'h1 << 17;
  localparam logic [32:0] WRITE     = 33'h1 << 18;
  localparam logic [32:0] READ      = 33'h1 << 19;
  localparam logic [32:0] IRIN      = 33'h1 << 20;
  localparam logic [32:0] MDROUT    = 33'h1 << 21;
  localparam logic [32:0] MDRIN     = 33'h1 << 22;
  localparam logic [32:0] MARIN     = 33'h1 << 23;
  localparam logic [32:0] INCPC     = 33'h1 << 24;
  localparam logic [32:0] PCIN      = 33'h1 << 25;
  localparam logic [32:0] PCOUT     = 33'h1 << 26;
  localparam logic [32:0] RUN       = 33'h1 << 32;
  localparam logic [32:0] ZERO      = '0;
  localparam logic [32:0] F0        = RUN | PCOUT | MARIN;
  localparam logic [32:0] F1        = RUN | READ | MDRIN | PCIN | INCPC;
  localparam logic [32:0] F2        = RUN | MDROUT | IRIN;
  localparam logic [32:0] A_ADD     = {1'b0, 5'b00011, 27'd0};
  localparam logic [32:0] A_ADDI    = {1'b0, 5'b01000, 27'd0};
  localparam logic [32:0] A_MUL     = {1'b0, 5'b01011, 27'd0};

  localparam logic [31:0] I_ADD  = 32'h18918000;
  localparam logic [31:0] I_JAL  = 32'hA2780000;
  localparam logic [31:0] I_BR   = 32'h90800000;
  localparam logic [31:0] I_LD   = 32'h00800000;
  localparam logic [31:0] I_ST   = 32'h10800000;
  localparam logic [31:0] I_MUL  = 32'h58000000;
  localparam logic [31:0] I_ADDI = 32'h40000000;
  localparam logic [31:0] I_LDI  = 32'h08000000;
  localparam logic [31:0] I_JR   = 32'h98000000;
  localparam logic [31:0] I_MFLO = 32'hC0000000;
  localparam logic [31:0] I_OUT  = 32'hB0000000;
  localparam logic [31:0] I_NOP  = 32'hC8000000;
  localparam logic [31:0] I_HALT = 32'hD0000000;
  localparam logic [31:0] I_UNDF = 32'hF8000000;

  logic [32:0] exp_q[$];
  string       name_q[$];
  logic [32:0] seq[$];
  int          total = 0;
  int          bad   = 0;

  initial begin : monitor
    logic [32:0] e;
    string       n;
    forever begin
      @(negedge Clock);
      if (($countones({Gra, Grb, Grc})) > 1) begin
        bad++;
        $display("FAIL more than one of Gra/Grb/Grc high: %b%b%b", Gra, Grb, Grc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s: got %h want %h", n, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Apply inputs, take one clock edge, and expect e afterwards.
  task automatic cyc(input logic rst, input logic [31:0] ir, input logic con,
                     input logic stop, input logic stp, input logic [32:0] e,
                     input string n);
    Reset = rst;
    IR    = ir;
    CON   = con;
    Stop  = stop;
`ifdef CU_SINGLE_STEP_EN
    Step  = stp;
`else
    step_unused = stp;
`endif
    @(posedge Clock);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge Clock);
    #1;
  endtask

  // Edge that leaves the final step of an instruction.
  task automatic finish_instr(input string n, input logic [31:0] ir);
`ifdef CU_SINGLE_STEP_EN
    cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, ZERO, {n, "_wait"});
    cyc(1'b0, ir, 1'b0, 1'b0, 1'b1, F0,   {n, "_step_t0"});
`else
    cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, F0,   {n, "_next_t0"});
`endif
  endtask

  // Starting in T0: expect seq for T1 onwards, then the boundary.
  task automatic exec(input string n, input logic [31:0] ir, input logic con);
    foreach (seq[i])
      cyc(1'b0, ir, con, 1'b0, 1'b0, seq[i], $sformatf("%s_s%0d", n, i + 1));
    finish_instr(n, ir);
  endtask

  initial begin : stim
    cyc(1'b1, I_ADD, 1'b0, 1'b0, 1'b0, ZERO, "reset1");
    cyc(1'b1, I_ADD, 1'b0, 1'b0, 1'b0, ZERO, "reset2");
    cyc(1'b0, I_ADD, 1'b0, 1'b0, 1'b0, F0,   "first_t0");

    seq = '{F1, F2, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZIN|A_ADD, RUN|ZLOOUT|GRA|RIN};
    exec("add", I_ADD, 1'b0);

    seq = '{F1, F2, RUN|PCOUT|GRB|RIN, RUN|GRA|ROUT|PCIN};
    exec("jal", I_JAL, 1'b0);

    seq = '{F1, F2, RUN|GRA|ROUT|CONIN, RUN|PCOUT|YIN, RUN|COUT|ZIN|A_ADD, RUN|ZLOOUT|PCIN};
    exec("br_taken", I_BR, 1'b1);
    seq = '{F1, F2, RUN|GRA|ROUT|CONIN, RUN|PCOUT|YIN, RUN|COUT|ZIN|A_ADD, RUN|ZLOOUT};
    exec("br_not", I_BR, 1'b0);

    seq = '{F1, F2, RUN|GRB|BAOUT|YIN, RUN|COUT|ZIN|A_ADD, RUN|ZLOOUT|MARIN,
            RUN|READ|MDRIN, RUN|MDROUT|GRA|RIN};
    exec("ld", I_LD, 1'b0);
    seq = '{F1, F2, RUN|GRB|BAOUT|YIN, RUN|COUT|ZIN|A_ADD, RUN|ZLOOUT|MARIN,
            RUN|GRA|ROUT|MDRIN, RUN|WRITE};
    exec("st", I_ST, 1'b0);

    seq = '{F1, F2, RUN|GRA|ROUT|YIN, RUN|GRB|ROUT|ZIN|A_MUL, RUN|ZLOOUT|LOIN, RUN|ZHIOUT|HIIN};
    exec("mul", I_MUL, 1'b0);
    seq = '{F1, F2, RUN|GRB|ROUT|YIN, RUN|COUT|ZIN|A_ADDI, RUN|ZLOOUT|GRA|RIN};
    exec("addi", I_ADDI, 1'b0);
    seq = '{F1, F2, RUN|GRB|BAOUT|YIN, RUN|COUT|ZIN|A_ADD, RUN|ZLOOUT|GRA|RIN};
    exec("ldi", I_LDI, 1'b0);
    seq = '{F1, F2, RUN|GRA|ROUT|PCIN};
    exec("jr", I_JR, 1'b0);
    seq = '{F1, F2, RUN|LOOUT|GRA|RIN};
    exec("mflo", I_MFLO, 1'b0);
    seq = '{F1, F2, RUN|GRA|ROUT|OUTPORTIN};
    exec("out", I_OUT, 1'b0);
    seq = '{F1, F2};
    exec("nop", I_NOP, 1'b0);
    seq = '{F1, F2};
    exec("undef", I_UNDF, 1'b0);

    // Stop pulsed while in ld T4 and dropped before the boundary.
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, F1,                      "stp_t1");
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, F2,                      "stp_t2");
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, RUN|GRB|BAOUT|YIN,       "stp_t3");
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, RUN|COUT|ZIN|A_ADD,      "stp_t4");
    cyc(1'b0, I_LD, 1'b0, 1'b1, 1'b0, RUN|ZLOOUT|MARIN,        "stp_t5");
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, RUN|READ|MDRIN,          "stp_t6");
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, RUN|MDROUT|GRA|RIN,      "stp_t7");
    finish_instr("stp_pulse", I_LD);

`ifdef CU_SINGLE_STEP_EN
    // WAIT holds with Step low; a held Step does not re-trigger.
    cyc(1'b0, I_NOP, 1'b0, 1'b0, 1'b0, F1, "ss_t1");
    cyc(1'b0, I_NOP, 1'b0, 1'b0, 1'b0, F2, "ss_t2");
    for (int k = 0; k < 4; k++)
      cyc(1'b0, I_NOP, 1'b0, 1'b0, 1'b0, ZERO, "ss_wait_hold");
    cyc(1'b0, I_NOP, 1'b0, 1'b0, 1'b1, F0, "ss_rise");
    cyc(1'b0, I_NOP, 1'b0, 1'b0, 1'b1, F1, "ss_held_t1");
    cyc(1'b0, I_NOP, 1'b0, 1'b0, 1'b1, F2, "ss_held_t2");
    for (int k = 0; k < 3; k++)
      cyc(1'b0, I_NOP, 1'b0, 1'b0, 1'b1, ZERO, "ss_held_wait");
    cyc(1'b0, I_NOP, 1'b0, 1'b0, 1'b0, ZERO, "ss_low_wait");
    cyc(1'b0, I_NOP, 1'b0, 1'b0, 1'b1, F0,   "ss_rise2");
`endif

    // Reset during st T6: the write step never happens.
    cyc(1'b0, I_ST, 1'b0, 1'b0, 1'b0, F1,                  "sab_t1");
    cyc(1'b0, I_ST, 1'b0, 1'b0, 1'b0, F2,                  "sab_t2");
    cyc(1'b0, I_ST, 1'b0, 1'b0, 1'b0, RUN|GRB|BAOUT|YIN,   "sab_t3");
    cyc(1'b0, I_ST, 1'b0, 1'b0, 1'b0, RUN|COUT|ZIN|A_ADD,  "sab_t4");
    cyc(1'b0, I_ST, 1'b0, 1'b0, 1'b0, RUN|ZLOOUT|MARIN,    "sab_t5");
    cyc(1'b0, I_ST, 1'b0, 1'b0, 1'b0, RUN|GRA|ROUT|MDRIN,  "sab_t6");
    cyc(1'b1, I_ST, 1'b0, 1'b0, 1'b0, ZERO,                "sab_rst");
    if (write !== 1'b0) begin
      bad++;
      $display("FAIL sab_rst_write: write=%b after reset in st T6", write);
    end
    cyc(1'b0, I_ST, 1'b0, 1'b0, 1'b0, F0,                  "sab_t0");

    // halt opcode parks in HALT until Reset.
    cyc(1'b0, I_HALT, 1'b0, 1'b0, 1'b0, F1,   "hop_t1");
    cyc(1'b0, I_HALT, 1'b0, 1'b0, 1'b0, F2,   "hop_t2");
    cyc(1'b0, I_HALT, 1'b0, 1'b0, 1'b0, ZERO, "hop_halt");
    cyc(1'b0, I_HALT, 1'b0, 1'b0, 1'b0, ZERO, "hop_stay");
    cyc(1'b1, I_HALT, 1'b0, 1'b0, 1'b0, ZERO, "hop_rst");
    cyc(1'b0, I_HALT, 1'b0, 1'b0, 1'b0, F0,   "hop_t0");

    // Stop held through the end of ld halts at the boundary.
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, F1,                  "sth_t1");
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, F2,                  "sth_t2");
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, RUN|GRB|BAOUT|YIN,   "sth_t3");
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, RUN|COUT|ZIN|A_ADD,  "sth_t4");
    cyc(1'b0, I_LD, 1'b0, 1'b1, 1'b0, RUN|ZLOOUT|MARIN,    "sth_t5");
    cyc(1'b0, I_LD, 1'b0, 1'b1, 1'b0, RUN|READ|MDRIN,      "sth_t6");
    cyc(1'b0, I_LD, 1'b0, 1'b1, 1'b0, RUN|MDROUT|GRA|RIN,  "sth_t7");
    cyc(1'b0, I_LD, 1'b0, 1'b1, 1'b0, ZERO,                "sth_halt");
    if (Run !== 1'b0) begin
      bad++;
      $display("FAIL sth_halt_run: Run=%b in HALT", Run);
    end
    cyc(1'b0, I_LD, 1'b0, 1'b1, 1'b0, ZERO,                "sth_stay");
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, ZERO,                "sth_sticky");
    cyc(1'b1, I_LD, 1'b0, 1'b0, 1'b0, ZERO,                "sth_rst");
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, F0,                  "sth_t0");
    cyc(1'b0, I_LD, 1'b0, 1'b0, 1'b0, F1,                  "sth_t1b");
    if (Run !== 1'b1) begin
      bad++;
      $display("FAIL sth_t1b_run: Run=%b after restart", Run);
    end

    @(negedge Clock);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard not drained: %0d pending", exp_q.size());
    end
    if (total < 12) begin
      bad++;
      $display("FAIL too few comparisons: total=%0d", total);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
